// File: rtl/slide_pkg.sv
// slide_pkg: constants and FSM state type for the ref10
// sliding-window scalar recoder (optional busy port: SLIDE_BUSY_EN).
package slide_pkg;

    localparam int NBITS     = 256;
    localparam int DIGIT_W   = 8;
    localparam int MAX_OFS   = 6;
    localparam int DIGIT_MAX = 15;
    localparam int IDX_W     = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SCAN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Byte j sits MSB-first at s[8j:8j+7]; return LSB-first scalar bits.
    function automatic logic [NBITS-1:0] scalar_bits(
        input logic [0:NBITS-1] s
    );
        logic [NBITS-1:0] o;
        o = '0;
        for (int i = 0; i < NBITS; i++) begin
            o[i] = s[(i / 8) * 8 + 7 - (i % 8)];
        end
        return o;
    endfunction

endpackage

// File: rtl/slide_carry.sv
// slide_carry: adds one at bit start_i of a bit vector by clearing
// the run of ones and setting the first zero; overflow is dropped.
module slide_carry
    import slide_pkg::*;
(
    input  logic [NBITS-1:0] vec_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [NBITS-1:0] vec_o
);

    // Find-first-zero at or above start_i, clearing the ones passed.
    always_comb begin
        logic run;
        vec_o = vec_i;
        run   = 1'b1;
        for (int k = 0; k < NBITS; k++) begin
            if (run && (k >= int'(start_i))) begin
                if (vec_i[k]) begin
                    vec_o[k] = 1'b0;
                end else begin
                    vec_o[k] = 1'b1;
                    run      = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/slide.sv
// slide: ref10 window-5 sliding recoder, one (i,b) step per cycle.
// Define SLIDE_BUSY_EN to add a busy output (high in LOAD/SCAN).
module slide
    import slide_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid,
    input  logic [0:NBITS-1]               a,
    output logic signed [0:NBITS*DIGIT_W-1] r,
    output logic                           done
`ifdef SLIDE_BUSY_EN
    ,
    output logic                           busy
`endif
);

    localparam logic signed [DIGIT_W-1:0] DMAX  = DIGIT_W'(DIGIT_MAX);
    localparam logic signed [DIGIT_W-1:0] NMAX  = -DMAX;
    localparam logic [2:0]                BLAST = 3'(MAX_OFS);
    localparam logic [2:0]                BONE  = 3'd1;

    state_t                      state_q;
    logic [NBITS-1:0]            bits_q;
    logic [IDX_W-1:0]            i_q;
    logic [2:0]                  b_q;
    logic signed [DIGIT_W-1:0]   cur_q;
    logic [0:NBITS*DIGIT_W-1]    r_q;
    logic                        done_q;

    logic [IDX_W:0]              idx;
    logic                        in_rng;
    logic                        hit;
    logic                        fin;
    logic signed [DIGIT_W-1:0]   v;
    logic signed [DIGIT_W-1:0]   plus;
    logic signed [DIGIT_W-1:0]   minus;
    logic signed [DIGIT_W-1:0]   cur_d;
    logic [NBITS-1:0]            bits_d;
    logic [NBITS-1:0]            carry_vec;

    slide_carry u_carry (
        .vec_i   (bits_q),
        .start_i (idx[IDX_W-1:0]),
        .vec_o   (carry_vec)
    );

    // One window step: fold bit i+b into digit i, or borrow and carry.
    always_comb begin
        idx    = {1'b0, i_q} + {{(IDX_W-2){1'b0}}, b_q};
        in_rng = ~idx[IDX_W];
        hit    = in_rng && bits_q[idx[IDX_W-1:0]];
        v      = DIGIT_W'(1) << b_q;
        plus   = cur_q + v;
        minus  = cur_q - v;
        bits_d = bits_q;
        cur_d  = cur_q;
        fin    = (b_q == BLAST);
        if ((cur_q == '0) || !in_rng) begin
            fin = 1'b1;
        end else if (hit) begin
            if (plus <= DMAX) begin
                cur_d                  = plus;
                bits_d[idx[IDX_W-1:0]] = 1'b0;
            end else if (minus >= NMAX) begin
                cur_d  = minus;
                bits_d = carry_vec;
            end else begin
                fin = 1'b1;
            end
        end
    end

    // Control FSM with registered done and digit storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            bits_q  <= '0;
            i_q     <= '0;
            b_q     <= '0;
            cur_q   <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (valid) begin
                        bits_q  <= scalar_bits(a);
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_q     <= '0;
                    i_q     <= '0;
                    b_q     <= BONE;
                    cur_q   <= {{(DIGIT_W-1){1'b0}}, bits_q[0]};
                    state_q <= S_SCAN;
                end
                S_SCAN: begin
                    bits_q <= bits_d;
                    if (fin) begin
                        r_q[{i_q, 3'b000} +: DIGIT_W] <= cur_d;
                        i_q   <= i_q + IDX_W'(1);
                        b_q   <= BONE;
                        cur_q <= {{(DIGIT_W-1){1'b0}},
                                  bits_d[i_q + IDX_W'(1)]};
                        if (i_q == '1) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cur_q <= cur_d;
                        b_q   <= b_q + BONE;
                    end
                end
                S_DONE: begin
                    if (valid) begin
                        bits_q  <= scalar_bits(a);
                        state_q <= S_LOAD;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign r    = r_q;
    assign done = done_q;

`ifdef SLIDE_BUSY_EN
    assign busy = (state_q == S_LOAD) || (state_q == S_SCAN);
`endif

endmodule

// File: tb/tb_slide.sv
// tb_slide: directed bench for slide against a software ref10
// slide model (builds with or without SLIDE_BUSY_EN).
module tb_slide;

    logic               clk = 1'b0;
    logic               rst;
    logic               valid;
    logic [0:255]       a;
    logic signed [0:2047] r;
    logic               done;
`ifdef SLIDE_BUSY_EN
    logic               busy;
`endif

    int  ntest = 0;
    int  nfail = 0;
    int  exp_d [256];
    bit  chk_en = 1'b0;

    slide dut (
        .clk   (clk),
        .rst   (rst),
        .valid (valid),
        .a     (a),
        .r     (r),
        .done  (done)
`ifdef SLIDE_BUSY_EN
        ,
        .busy  (busy)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input longint act,
                         input longint req);
        ntest++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endtask

    function automatic int dig(input int i);
        logic [7:0] t;
        t = r[8*i +: 8];
        return int'($signed(t));
    endfunction

    function automatic int nz_count();
        int n;
        n = 0;
        for (int i = 0; i < 256; i++) if (dig(i) != 0) n++;
        return n;
    endfunction

    // Software ref10 slide on an int array.
    task automatic set_exp(input logic [0:255] av);
        int v;
        bit stop;
        bit go;
        for (int i = 0; i < 256; i++)
            exp_d[i] = int'(av[8*(i/8) + 7 - (i%8)]);
        for (int i = 0; i < 256; i++) begin
            if (exp_d[i] != 0) begin
                stop = 1'b0;
                for (int b = 1; b <= 6 && i + b <= 255 && !stop; b++) begin
                    if (exp_d[i+b] != 0) begin
                        v = 1 << b;
                        if (exp_d[i] + v <= 15) begin
                            exp_d[i]   += v;
                            exp_d[i+b]  = 0;
                        end else if (exp_d[i] - v >= -15) begin
                            exp_d[i] -= v;
                            go = 1'b1;
                            for (int k = i + b; k < 256 && go; k++) begin
                                if (exp_d[k] == 0) begin
                                    exp_d[k] = 1;
                                    go = 1'b0;
                                end else begin
                                    exp_d[k] = 0;
                                end
                            end
                        end else begin
                            stop = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    // Every cycle a result is presented, it must match the model.
    always @(negedge clk) begin
        if (chk_en && done) begin
            int bad;
            bad = -1;
            for (int i = 0; i < 256; i++)
                if (bad < 0 && dig(i) != exp_d[i]) bad = i;
            ntest++;
            if (bad >= 0) begin
                nfail++;
                $display("FAIL model_cmp digit %0d: got %0d, want %0d",
                         bad, dig(bad), exp_d[bad]);
            end
        end
    end

    task automatic start(input logic [0:255] av);
        @(negedge clk);
        a     = av;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        a     = ~av;
        check("done_drop", done, 0);
`ifdef SLIDE_BUSY_EN
        check("busy_run", busy, 1);
`endif
        set_exp(av);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("done_timeout", done, 1);
`ifdef SLIDE_BUSY_EN
        check("busy_done", busy, 0);
`endif
    endtask

    task automatic check_props(input logic [0:255] av);
        logic signed [263:0] acc;
        logic signed [263:0] t;
        logic [255:0]        s;
        int                  d;
        int                  bad;
        acc = '0;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            s[i] = av[8*(i/8) + 7 - (i%8)];
            d    = dig(i);
            t    = d;
            acc  = acc + (t <<< i);
            if (d != 0 && ((d % 2) == 0 || d > 15 || d < -15)) bad++;
        end
        check("sum_eq_scalar", acc == $signed({8'b0, s}), 1);
        check("odd_in_range", bad, 0);
    endtask

    initial begin
        int           cyc;
        logic [0:255] big;
        logic [0:255] ones;
        logic [0:255] v2;
        logic [0:255] v3;
        big  = 256'h42e6b3da746f7982c72e3945ca2e987362ae2af25aa079470fd723b60d430c0a;
        v2   = 256'h8000000000000000ffffffff00000000123456789abcdef0fedcba9876543210;
        v3   = 256'hdeadbeefcafebabe0badf00d1234567855aa55aa55aa55aa00ff00ff0f0f0f0f;
        ones = '1;
        rst   = 1'b0;
        valid = 1'b0;
        a     = '0;
        #3;
        check("rst_done", done, 0);
        check("rst_r_zero", r == '0, 1);
`ifdef SLIDE_BUSY_EN
        check("rst_busy", busy, 0);
`endif
        @(negedge clk);
        rst = 1'b1;

        start('0);
        chk_en = 1'b1;
        wait_done(cyc);
        check("zero_r", r == '0, 1);

        start({8'h0F, 248'h0});
        check("pin_0f_d0", exp_d[0], 15);
        wait_done(cyc);
        check("dut_0f_d0", dig(0), 15);
        check("dut_0f_nz", nz_count(), 1);

        start({8'h1F, 248'h0});
        check("pin_1f_d0", exp_d[0], -1);
        check("pin_1f_d5", exp_d[5], 1);
        wait_done(cyc);
        check("dut_1f_d0", dig(0), -1);
        check("dut_1f_d5", dig(5), 1);
        check("dut_1f_nz", nz_count(), 2);

        start(big);
        wait_done(cyc);
        check("latency_big", cyc <= 1794, 1);
        check_props(big);

        start(ones);
        wait_done(cyc);
        check("latency_ones", cyc <= 1794, 1);

        start(v2);
        repeat (30) @(negedge clk);
        check("scan_done_low", done, 0);
        a     = big;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        wait_done(cyc);
        check_props(v2);

        repeat (3) @(negedge clk);
        start(v3);
        wait_done(cyc);
        check_props(v3);

        start(big);
        repeat (200) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_done", done, 0);
        check("midrst_r_zero", r == '0, 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_after_rst", done, 0);
        start(v3);
        wait_done(cyc);
        check_props(v3);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
